regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 106 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins on collision), NRD read
// lanes with write-through bypass, and a self-sequencing zeroing pass after reset or clear.
module regfile_mp #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int RD_REG = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    output logic              ready_o,
    input  logic              we0_i,
    input  logic [AW-1:0]     waddr0_i,
    input  logic [DW-1:0]     wdata0_i,
    input  logic              we1_i,
    input  logic [AW-1:0]     waddr1_i,
    input  logic [DW-1:0]     wdata1_i,
    input  logic [NRD-1:0]    re_i,
    input  logic [NRD*AW-1:0] raddr_i,
    output logic [NRD*DW-1:0] rdata_o
);
    localparam int DEPTH = 2**AW;

    typedef enum logic {CLEAR, READY} state_e;

    state_e         state_q;
    logic [AW-1:0]  cnt_q;
    logic           ready_q;
    logic [DW-1:0]  mem_q [DEPTH];
    logic           wr0_en;
    logic           wr1_en;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (cnt_q == {AW{1'b1}}) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                READY: begin
                    if (clr_i) begin
                        state_q <= CLEAR;
                        ready_q <= 1'b0;
                        cnt_q   <= AW'(1);
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    ready_q <= 1'b0;
                    cnt_q   <= AW'(1);
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign wr0_en  = ready_q && we0_i && (waddr0_i != '0);
    assign wr1_en  = ready_q && we1_i && (waddr1_i != '0);

    // Storage is never reset; the CLEAR walk is the only way entries return to zero.
    // Port 1 is written last so it overrides port 0 on an address collision.
    always_ff @(posedge clk_i) begin
        if (!ready_q) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr0_en) mem_q[waddr0_i] <= wdata0_i;
            if (wr1_en) mem_q[waddr1_i] <= wdata1_i;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rd_d;

        assign ra = raddr_i[gi*AW +: AW];

        always_comb begin
            rd_d = '0;
            if (ready_q && re_i[gi] && (ra != '0)) begin
                if (we1_i && (waddr1_i == ra))      rd_d = wdata1_i;
                else if (we0_i && (waddr0_i == ra)) rd_d = wdata0_i;
                else                                rd_d = mem_q[ra];
            end
        end

        if (RD_REG != 0) begin : g_reg
            logic [DW-1:0] rd_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) rd_q <= '0;
                else       rd_q <= rd_d;
            end
            assign rdata_o[gi*DW +: DW] = rd_q;
        end else begin : g_comb
            assign rdata_o[gi*DW +: DW] = rd_d;
        end
    end
endmodule
